// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and board defaults for the divided-clock frequency monitor
package clk_mon_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } mon_state_t;

    // 1000-cycle gate against a divide-by-8 output: 125 edges nominal
    localparam int DEF_GATE_CYCLES  = 1000;
    localparam int DEF_CNT_W        = 12;
    localparam int DEF_MIN_EDGES    = 120;
    localparam int DEF_MAX_EDGES    = 130;
    localparam int DEF_LOCK_WINDOWS = 4;
    localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with a one-cycle rising-edge pulse
module sync_edge_detect
    import clk_mon_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - gated edge counter that range-checks a divided clock and reports lock/fault
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int MIN_EDGES    = DEF_MIN_EDGES,
    parameter int MAX_EDGES    = DEF_MAX_EDGES,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mon_clk,
    input  logic             clear_fault,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             fault
);

    localparam int GATE_W   = $clog2(GATE_CYCLES);
    localparam int STREAK_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    MIN_C     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]    MAX_C     = CNT_W'(MAX_EDGES);
    localparam logic [STREAK_W-1:0] LOCK_C    = STREAK_W'(LOCK_WINDOWS);

    mon_state_t          state;
    mon_state_t          state_next;
    logic [GATE_W-1:0]   gate_cnt;
    logic [CNT_W-1:0]    edge_cnt;
    logic [CNT_W-1:0]    edge_sum;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_inc;
    logic                rise;
    logic                window_end;
    logic                result_ok;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mon_clk),
        .rise  (rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        window_end = 1'b0;
        edge_sum   = edge_cnt;
        streak_inc = streak;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else begin
                    window_end = (gate_cnt == GATE_LAST);
                end
            end
            default: state_next = IDLE;
        endcase
        // a rise on the last gate cycle is folded into the closing window
        if (rise && (edge_cnt != CNT_MAX)) begin
            edge_sum = edge_cnt + CNT_W'(1);
        end
        result_ok = (edge_sum >= MIN_C) && (edge_sum <= MAX_C);
        if (streak != LOCK_C) begin
            streak_inc = streak + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            streak     <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if ((state == MEASURE) && enable) begin
                if (window_end) begin
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    meas_count <= edge_sum;
                    meas_valid <= 1'b1;
                    in_range   <= result_ok;
                    if (result_ok) begin
                        streak <= streak_inc;
                        locked <= (streak_inc == LOCK_C);
                    end else begin
                        streak <= '0;
                        locked <= 1'b0;
                    end
                end else begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                    edge_cnt <= edge_sum;
                end
            end else begin
                // idle or leaving a window: the partial count is thrown away
                gate_cnt <= '0;
                edge_cnt <= '0;
                if (!enable) begin
                    streak <= '0;
                    locked <= 1'b0;
                end
            end

            if (window_end && !result_ok) begin
                fault <= 1'b1;
            end else if (clear_fault) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb/tb_clk_freq_monitor.sv - self-checking bench for clk_freq_monitor
module tb_clk_freq_monitor;

    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        mon_clk = 1'b0;
    logic        clear_fault = 1'b0;
    logic [11:0] meas_count;
    logic        meas_valid;
    logic        in_range;
    logic        locked;
    logic        fault;

    clk_freq_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mon_clk     (mon_clk),
        .clear_fault (clear_fault),
        .meas_count  (meas_count),
        .meas_valid  (meas_valid),
        .in_range    (in_range),
        .locked      (locked),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int clr;
        int cnt;
        int inr;
        int lk;
        int flt;
    } row_t;

    row_t tbl[17];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model: window bounds plus a list of mon_clk rise times
    bit m_run, m_mv, m_in, m_lk, m_f;
    int m_s, m_cnt, m_streak;
    int rises[$];

    int pat_mode = 0, pat_lo = 4, pat_hi = 4, ph = 0;
    bit mon_prev = 1'b0;
    bit pend_v = 1'b0;
    int pend_at, pend_mode, pend_lo, pend_hi;
    int pulse_at = -100;
    int clr_at = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_mv = 0; m_in = 0; m_lk = 0; m_f = 0;
        m_s = 0; m_cnt = 0; m_streak = 0;
    endtask

    // a rise driven in cycle n is counted in gate cycle n+2
    function automatic int window_count(input int s);
        int c = 0;
        foreach (rises[i]) if (rises[i] >= s - 2 && rises[i] <= s + GATE - 3) c++;
        while (rises.size() > 0 && rises[0] < s + GATE - 2) void'(rises.pop_front());
        return (c > 4095) ? 4095 : c;
    endfunction

    task automatic model_edge(input bit en, input bit clr);
        if (reset) begin
            model_reset();
            return;
        end
        m_mv = 0;
        if (!m_run) begin
            if (en) begin m_run = 1; m_s = cyc; end
        end else if (!en) begin
            m_run = 0; m_streak = 0; m_lk = 0;
        end else if (cyc == m_s + GATE) begin
            m_cnt = window_count(m_s);
            m_mv = 1;
            m_in = (m_cnt >= 120 && m_cnt <= 130);
            if (m_in) begin
                if (m_streak < 4) m_streak++;
                m_lk = (m_streak == 4);
            end else begin
                m_streak = 0; m_lk = 0;
            end
            m_s = cyc;
        end
        if (m_mv && !m_in) m_f = 1;
        else if (clr) m_f = 0;
    endtask

    task automatic drive_inputs();
        bit v;
        if (pend_v && cyc == pend_at) begin
            pat_mode = pend_mode; pat_lo = pend_lo; pat_hi = pend_hi; ph = 0; pend_v = 0;
        end
        case (pat_mode)
            1: begin v = (ph >= pat_lo); ph = (ph + 1) % (pat_lo + pat_hi); end
            2: v = (cyc >= pulse_at && cyc < pulse_at + 3);
            default: v = 1'b0;
        endcase
        if (v && !mon_prev) rises.push_back(cyc);
        mon_prev = v;
        mon_clk = v;
        clear_fault = (cyc == clr_at);
    endtask

    task automatic step();
        bit en, clr;
        en = enable;
        clr = clear_fault;
        @(posedge clk);
        cyc++;
        model_edge(en, clr);
        #1;
        check("meas_valid", int'(meas_valid), int'(m_mv));
        check("meas_count", int'(meas_count), m_cnt);
        check("in_range", int'(in_range), int'(m_in));
        check("locked", int'(locked), int'(m_lk));
        check("fault", int'(fault), int'(m_f));
        drive_inputs();
    endtask

    task automatic sched(input int per, input int at);
        pend_v = 1; pend_at = at;
        pend_mode = (per == 0) ? 0 : 1;
        pend_lo = per / 2; pend_hi = per - per / 2;
    endtask

    task automatic wait_result(input string tag);
        int k = 0;
        do begin step(); k++; end while (!m_mv && k < GATE + 100);
        check({tag, "_result_seen"}, int'(meas_valid), 1);
    endtask

    initial begin
        tbl[0]  = '{8, 0, 125, 1, 0, 0};
        tbl[1]  = '{8, 0, 125, 1, 0, 0};
        tbl[2]  = '{8, 0, 125, 1, 0, 0};
        tbl[3]  = '{8, 0, 125, 1, 1, 0};
        tbl[4]  = '{0, 0,   0, 0, 0, 1};
        tbl[5]  = '{8, 0, 125, 1, 0, 1};
        tbl[6]  = '{8, 0, 125, 1, 0, 1};
        tbl[7]  = '{8, 2, 125, 1, 0, 0};
        tbl[8]  = '{8, 0, 125, 1, 1, 0};
        tbl[9]  = '{4, 0, 250, 0, 0, 1};
        tbl[10] = '{8, 0, 125, 1, 0, 1};
        tbl[11] = '{8, 0, 125, 1, 0, 1};
        tbl[12] = '{8, 0, 125, 1, 0, 1};
        tbl[13] = '{8, 0, 125, 1, 1, 1};
        tbl[14] = '{8, 2, 125, 1, 1, 0};
        tbl[15] = '{0, 1,   0, 0, 0, 1};
        tbl[16] = '{8, 3, 125, 1, 0, 0};

        model_reset();
        repeat (3) step();
        check("rst_meas_count", int'(meas_count), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        reset = 1'b0;
        sched(tbl[0].per, cyc + 1);
        repeat (20) step();

        // table: one window per row, pattern switched two cycles before the window opens
        enable = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            if (i + 1 < 17) sched(tbl[i + 1].per, m_s + GATE - 2);
            if (tbl[i].clr == 1) clr_at = m_s + GATE - 1;
            if (tbl[i].clr == 2) clr_at = m_s + 500;
            if (tbl[i].clr == 3) begin
                clear_fault = 1'b1;
                step();
                check("clear_after_set_fault", int'(fault), 0);
            end
            wait_result("tbl");
            check("tbl_meas_count", int'(meas_count), tbl[i].cnt);
            check("tbl_in_range", int'(in_range), tbl[i].inr);
            check("tbl_locked", int'(locked), tbl[i].lk);
            check("tbl_fault", int'(fault), tbl[i].flt);
        end

        // enable dropped at gate_cnt 500, then re-enabled
        begin
            int seen = 0;
            int k = 0;
            while (cyc < m_s + 500) step();
            enable = 1'b0;
            for (int j = 0; j < 1200; j++) begin
                step();
                if (meas_valid) seen++;
            end
            check("dis_valid_seen", seen, 0);
            check("dis_locked", int'(locked), 0);
            check("dis_meas_count", int'(meas_count), 125);
            enable = 1'b1;
            do begin step(); k++; end while (!meas_valid && k < 1100);
            check("reenable_latency", k, GATE + 1);
            for (int j = 0; j < 3; j++) begin
                wait_result("relock");
                check("relock_locked", int'(locked), (j == 2) ? 1 : 0);
            end
        end

        // reset mid-window while locked
        while (cyc < m_s + 300) step();
        reset = 1'b1;
        enable = 1'b0;
        #1;
        model_reset();
        check("midrst_meas_count", int'(meas_count), 0);
        check("midrst_in_range", int'(in_range), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_fault", int'(fault), 0);
        repeat (4) step();
        reset = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_result("postrst");
            check("postrst_count", int'(meas_count), 125);
            check("postrst_locked", int'(locked), (j == 3) ? 1 : 0);
        end

        // single rises aligned to the last gate cycle and to the first of the next window
        sched(0, m_s + GATE - 2);
        wait_result("pre_edge");
        pat_mode = 2;
        pulse_at = m_s + GATE - 3;
        wait_result("edge_last");
        check("edge_last_count", int'(meas_count), 1);
        pulse_at = m_s + GATE - 2;
        wait_result("edge_after");
        check("edge_after_count", int'(meas_count), 0);
        wait_result("edge_next");
        check("edge_next_count", int'(meas_count), 1);

        // random duty/period windows against the model
        for (int i = 0; i < 12; i++) begin
            int lo, hi;
            lo = $urandom_range(2, 6);
            hi = $urandom_range(2, 6);
            pend_v = 1; pend_at = m_s + GATE - 2; pend_mode = 1; pend_lo = lo; pend_hi = hi;
            if ($urandom_range(0, 3) == 0) clr_at = m_s + $urandom_range(1, GATE - 1);
            wait_result("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
